bnn_seq_ctrl: RTL

//  Parametrised program sequencer for the BNN processing unit; next generation of the BPU controller.

---
 rtl/bnn_pkg.sv | 34 +++
 rtl/bnn_seq_regfile.sv | 32 +++
 rtl/bnn_seq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared opcodes, mem_op codes and FSM encoding for the BNN program sequencer.
// Instruction format: opcode in [15:11], register/immediate fields below.
package bnn_pkg;

    localparam int INST_W = 16;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDL  = 5'b00001;
    localparam logic [4:0] OP_LDH  = 5'b00010;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_CMP  = 5'b00100;
    localparam logic [4:0] OP_JMP  = 5'b00101;
    localparam logic [4:0] OP_CORE = 5'b00110;
    localparam logic [4:0] OP_MEM  = 5'b00111;
    localparam logic [4:0] OP_WAIT = 5'b01000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [1:0] MEM_WEIGHT = 2'b00;
    localparam logic [1:0] MEM_BIAS   = 2'b01;
    localparam logic [1:0] MEM_IMAGE  = 2'b10;
    localparam logic [1:0] MEM_STORE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_ISSUE,
        S_WAITC,
        S_HALT,
        S_STALL
    } state_e;

endpackage

// File: rtl/bnn_seq_regfile.sv
// General register file for the sequencer: one write port, two
// combinational read ports, asynchronously cleared.
module bnn_seq_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/bnn_seq_ctrl.sv
// BNN processing-unit program sequencer: fetch/latch/exec with core and data-SRAM issue.
// Optional single-step gating via macro BNN_SEQ_STEP_EN (adds input step).
module bnn_seq_ctrl
    import bnn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
`ifdef BNN_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              core_valid,
    input  logic              core_ready,
    output logic [10:0]       core_op,
    output logic [DATA_W-1:0] core_arg,
    input  logic              core_busy,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [1:0]        mem_op,
    output logic [DATA_W-1:0] mem_addr
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'(16'h00FF);
    localparam logic [DATA_W-1:0] HI_MASK = DATA_W'(16'hFF00);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [INST_W-1:0] ir_q, ir_d;
    logic              flag_q, flag_d;
    logic              err_q, err_d;

    logic [4:0]        opc;
    logic [7:0]        imm;
    logic [AW-1:0]     rs_idx, rb_idx;
    logic [DATA_W-1:0] rs_val, rb_val, wdata;
    logic              we, is_core, hs, fetch_ok;
    state_e            resume;

    assign opc     = ir_q[15:11];
    assign imm     = ir_q[7:0];
    assign rs_idx  = ir_q[8 +: AW];
    assign is_core = (opc == OP_CORE);
    // Port B serves both r0 for core_arg and inst[8:6] for mem_addr
    assign rb_idx  = is_core ? '0 : ir_q[6 +: AW];
    assign pc_inc  = pc_q + PC_W'(1);

`ifdef BNN_SEQ_STEP_EN
    assign fetch_ok = step;
`else
    assign fetch_ok = 1'b1;
`endif
    assign resume = fetch_ok ? S_FETCH : S_STALL;

    bnn_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (rs_idx),
        .wdata   (wdata),
        .raddr_a (rs_idx),
        .rdata_a (rs_val),
        .raddr_b (rb_idx),
        .rdata_b (rb_val)
    );

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_HALT);
    assign err        = err_q;
    assign imem_en    = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign core_valid = (state_q == S_ISSUE) && is_core;
    assign mem_valid  = (state_q == S_ISSUE) && !is_core;
    assign core_op    = core_valid ? ir_q[10:0] : '0;
    assign core_arg   = core_valid ? rb_val : '0;
    assign mem_op     = mem_valid ? ir_q[10:9] : '0;
    assign mem_addr   = mem_valid ? rb_val : '0;
    assign hs         = (core_valid && core_ready) || (mem_valid && mem_ready);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flag_d  = flag_q;
        err_d   = err_q;
        we      = 1'b0;
        wdata   = rs_val;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = imem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = resume;
                pc_d    = pc_inc;
                case (opc)
                    OP_NOP: ;
                    OP_LDL: begin
                        we    = 1'b1;
                        wdata = (rs_val & ~LO_MASK) | DATA_W'(imm);
                    end
                    OP_LDH: begin
                        we    = 1'b1;
                        wdata = (rs_val & ~HI_MASK)
                              | ((DATA_W'(imm) << 8) & HI_MASK);
                    end
                    OP_ADDI: begin
                        we    = 1'b1;
                        wdata = rs_val + DATA_W'($signed(imm));
                    end
                    OP_CMP: flag_d = (rs_val > DATA_W'(imm));
                    OP_JMP: begin
                        if (flag_q) pc_d = pc_q - PC_W'(ir_q[10:0]);
                    end
                    OP_CORE, OP_MEM: begin
                        state_d = S_ISSUE;
                        pc_d    = pc_q;
                    end
                    OP_WAIT: begin
                        state_d = S_WAITC;
                        pc_d    = pc_q;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: begin
                        state_d = S_IDLE;
                        pc_d    = pc_q;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_ISSUE: begin
                if (hs) begin
                    pc_d    = pc_inc;
                    state_d = resume;
                end
            end
            S_WAITC: begin
                if (!core_busy) begin
                    pc_d    = pc_inc;
                    state_d = resume;
                end
            end
            S_HALT: state_d = S_IDLE;
            S_STALL: begin
                if (fetch_ok) state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
        end
    end

endmodule
